dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Responder end of the CPU data-memory port: serves load/store requests with a valid/ready handshake.
//   Holds DEPTH_WORDS x 32-bit storage, applies per-byte write enables and returns one response per request.
//   Has a programmable response latency and handles one request at a time.
//   Sits between the core's load/store path and on-chip data RAM.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words in storage; power of two, >= 2
//   LATENCY      2     wait cycles between request accept and rsp_valid assertion; 0..15
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   req_be     in   4   byte enables for a store; bit i controls bits [8i+7:8i]
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts the response
//   rsp_rdata  out  32  load data (0 for stores and for errored requests)
//   rsp_err    out  1   request faulted (misaligned or out of range)
// BEHAVIOUR
//   - Reset values: req_ready=0 while rst=1 and 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   - Reset leaves storage contents unchanged.
//   - FSM, reset state IDLE:
//       IDLE: req_ready=1. On accept (req_valid & req_ready): go to WAIT if LATENCY>0, else to RESP.
//       WAIT: load the counter with LATENCY-1 on entry and decrement it each cycle; go to RESP when it reaches 0.
//       RESP: rsp_valid=1. On rsp_valid & rsp_ready, go to IDLE.
//   - Latency: rsp_valid first rises LATENCY+1 cycles after the accept edge.
//     Throughput is at most one request every LATENCY+2 cycles (IDLE, WAIT x LATENCY, RESP).
//   - req_ready=0 in WAIT and RESP. Requester inputs are ignored outside an IDLE accept.
//   - All request fields are captured at the accept edge.
//   - Word index = req_addr[$clog2(DEPTH_WORDS)+1:2].
//   - Misaligned (req_addr[1:0]!=0): rsp_err=1, no write, rsp_rdata=0.
//   - Store: bytes with req_be=1 are written at the accept edge; other bytes keep their value.
//     be=4'b0000 is a legal no-op store with err=0.
//   - Load: storage is read at the accept edge; rsp_rdata holds that word.
//   - rsp_rdata and rsp_err are held stable while rsp_valid=1 && rsp_ready=0.
//   - rsp_ready asserted before RESP has no effect. If it is already high on entry to RESP, the response completes in that one cycle.
//   - Reset mid-operation: the pending response is dropped (rsp_valid=0 asynchronously) and the FSM returns to IDLE.
//     A store already accepted stays committed.
//   - Counter width is $clog2(LATENCY+1) with a minimum of 1 bit.
// CONFIGURATION
//   DMEM_RANGE_CHECK_EN defined:
//     req_addr[31:2] >= DEPTH_WORDS gives rsp_err=1, no write, rsp_rdata=0.
//     The response latency is the same as for a normal request.
//   DMEM_RANGE_CHECK_EN undefined:
//     Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
//     Out-of-range requests succeed with rsp_err=0.
// STRUCTURE
//   - Shared package dmem_pkg:
//       dmem_state_t enum {IDLE, WAIT, RESP}
//       DMEM_WORD_BYTES=4
//       DMEM_BE_ALL=4'b1111
//   - One sub-module, dmem_sram_array: storage with a synchronous byte-enabled write and a read port.
//     dmem_responder holds the FSM, address checks and response registers.
// TESTING
//   1. LATENCY=2: store addr=0x10, data=0xDEADBEEF, be=1111, then load 0x10.
//      Each rsp_valid rises 3 cycles after its accept; the load returns 0xDEADBEEF with err=0.
//   2. Word holds 0xDEADBEEF; store data=0x000000AA, be=0001 to 0x10, then load 0x10.
//      The load returns 0xDEADBEAA.
//   3. Load addr=0x12: err=1, rdata=0. Then store 0x13 with be=1111: err=1, and a later load of 0x10 shows the word unchanged.
//   4. Hold rsp_ready=0 for 5 cycles in RESP.
//      rsp_valid stays 1, rdata/err are stable and req_ready=0; one cycle after rsp_ready=1 the FSM is back in IDLE.
//   5. DEPTH_WORDS=1024, load addr=0x1000.
//      With DMEM_RANGE_CHECK_EN: err=1. Without it: returns the word at 0x0 with err=0.
//   6. Assert rst in WAIT after a store of 0x55 to 0x20: rsp_valid=0 immediately and req_ready=1 after release.
//      A later load of 0x20 returns 0x55.
//   Run with LATENCY=0 as well: rsp_valid one cycle after accept, back-to-back throughput of one request per 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DMEM_RANGE_CHECK_EN (see dmem_responder.sv).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES = 4;
  localparam logic [3:0]  DMEM_BE_ALL     = 4'b1111;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core load/store path and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_sram_array.sv
// Word-organised storage: synchronous byte-enabled write, asynchronous read. No reset on contents.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DMEM_WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable response latency.
// Define DMEM_RANGE_CHECK_EN to fault addresses beyond DEPTH_WORDS instead of aliasing them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam bit          HAS_WAIT = (LATENCY > 0);
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  dmem_state_t   state, next_state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic          mem_we;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rdata;
  logic [31:0]   rdata_q;
  logic          err_q;

  assign accept     = bus.req_valid & bus.req_ready;
  assign misaligned = |bus.req_addr[1:0];
  assign word_idx   = bus.req_addr[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign out_of_range = ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS);
`else
  // Upper address bits alias; fold them so they are not flagged as dangling.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];
  assign out_of_range   = 1'b0;
`endif

  assign req_err = misaligned | out_of_range;
  assign mem_we  = accept & bus.req_we & ~req_err;

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (bus.req_be),
    .addr  (word_idx),
    .wdata (bus.req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              cnt <= '0;
    else if (accept)                      cnt <= CNT_LOAD;
    else if (state == WAIT && cnt != '0)  cnt <= cnt - 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = HAS_WAIT ? WAIT : RESP;
      WAIT: if (cnt == '0) next_state = RESP;
      RESP: if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Response payload is fixed at accept time and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (bus.req_we | req_err) ? '0 : mem_rdata;
    end
  end

  assign bus.req_ready = (state == IDLE) & ~rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance plus a LATENCY=0 instance for throughput.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; hold = cycles rsp_ready stays low in RESP.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int unsigned hold,
                     output int unsigned lat, output logic [31:0] rdata, output logic err);
    int unsigned n = 0;
    chk1("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFC;
    bus.req_wdata = 32'h0;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat   = n + 1;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int unsigned i = 0; i < hold; i++) begin
      // Junk store offered while busy must be ignored.
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10;
      bus.req_be = DMEM_BE_ALL; bus.req_wdata = 32'h0;
      chk1("hold_valid", bus.rsp_valid, 1'b1);
      chk1("hold_req_ready", bus.req_ready, 1'b0);
      chk("hold_rdata", bus.rsp_rdata, rdata);
      chk1("hold_err", bus.rsp_err, err);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk1("rsp_done_valid", bus.rsp_valid, 1'b0);
    chk1("rsp_done_ready", bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    logic [31:0] rd;
    logic        er;
    int unsigned acc;
    int unsigned rsps;

    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_be = 0; bus.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0; bus0.req_be = 0; bus0.rsp_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rel_req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;

    // Store then load with full byte enables
    txn(1'b1, 32'h10, 32'hDEADBEEF, DMEM_BE_ALL, 0, lat, rd, er);
    chk("t1_store_lat", lat, 32'd3);
    chk1("t1_store_err", er, 1'b0);
    chk("t1_store_rdata", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("t1_load_lat", lat, 32'd3);
    chk("t1_load_rdata", rd, 32'hDEADBEEF);
    chk1("t1_load_err", er, 1'b0);

    // Partial byte write
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, lat, rd, er);
    chk1("t2_store_err", er, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("t2_load_rdata", rd, 32'hDEADBEAA);

    // Misaligned accesses fault and do not write
    txn(1'b0, 32'h12, 32'h0, 4'b0000, 0, lat, rd, er);
    chk1("t3_mis_load_err", er, 1'b1);
    chk("t3_mis_load_rdata", rd, 32'h0);
    chk("t3_mis_load_lat", lat, 32'd3);
    txn(1'b1, 32'h13, 32'h12345678, DMEM_BE_ALL, 0, lat, rd, er);
    chk1("t3_mis_store_err", er, 1'b1);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("t3_unchanged", rd, 32'hDEADBEAA);

    // be=0000 store is a no-op
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, lat, rd, er);
    chk1("be0_err", er, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("be0_unchanged", rd, 32'hDEADBEAA);

    // Back-pressure: rsp_ready low for 5 cycles in RESP
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 5, lat, rd, er);
    chk("t4_rdata", rd, 32'hDEADBEAA);
    chk1("t4_err", er, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("t4_no_junk_write", rd, 32'hDEADBEAA);

    // Out-of-range address
    txn(1'b1, 32'h0, 32'hCAFEF00D, DMEM_BE_ALL, 0, lat, rd, er);
    txn(1'b0, 32'h1000, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("t5_lat", lat, 32'd3);
`ifdef DMEM_RANGE_CHECK_EN
    chk1("t5_oor_err", er, 1'b1);
    chk("t5_oor_rdata", rd, 32'h0);
`else
    chk1("t5_alias_err", er, 1'b0);
    chk("t5_alias_rdata", rd, 32'hCAFEF00D);
`endif
    txn(1'b1, 32'h1000, 32'h0BADBEEF, DMEM_BE_ALL, 0, lat, rd, er);
    txn(1'b0, 32'h0, 32'h0, 4'b0000, 0, lat, rd, er);
`ifdef DMEM_RANGE_CHECK_EN
    chk("t5_oor_no_write", rd, 32'hCAFEF00D);
`else
    chk("t5_alias_write", rd, 32'h0BADBEEF);
`endif

    // Reset during WAIT after an accepted store
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h55; bus.req_be = DMEM_BE_ALL;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    rst = 1'b1;
    #1;
    chk1("t6_rst_valid", bus.rsp_valid, 1'b0);
    chk1("t6_rst_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk1("t6_rel_ready", bus.req_ready, 1'b1);
    chk("t6_rel_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    txn(1'b0, 32'h20, 32'h0, 4'b0000, 0, lat, rd, er);
    chk("t6_store_kept", rd, 32'h55);

    // Reset while a response is pending drops rsp_valid at once
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rspreset_pre_valid", bus.rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rspreset_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=0 instance: single-cycle response, then back-to-back loads
    bus0.rsp_ready = 1'b1;
    chk1("l0_ready", bus0.req_ready, 1'b1);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h4;
    bus0.req_wdata = 32'h11223344; bus0.req_be = DMEM_BE_ALL;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    chk1("l0_store_valid", bus0.rsp_valid, 1'b1);
    chk1("l0_store_err", bus0.rsp_err, 1'b0);
    chk1("l0_busy", bus0.req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("l0_done_valid", bus0.rsp_valid, 1'b0);
    chk1("l0_done_ready", bus0.req_ready, 1'b1);

    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h4;
    acc  = 0;
    rsps = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.req_valid && bus0.req_ready) acc++;
      if (bus0.rsp_valid) begin
        rsps++;
        chk("l0_b2b_rdata", bus0.rsp_rdata, 32'h11223344);
      end
      @(posedge clk); #1;
    end
    bus0.req_valid = 1'b0;
    chk("l0_b2b_accepts", acc, 32'd5);
    chk("l0_b2b_responses", rsps, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
